// File: rtl/nv_nvdla_sdp_nrdma_slcg_ctrl.sv
// SDP NRDMA clock-gate control: keeps the NRDMA clock requested from
// layer start until reads drain, plus an idle hold between layers.
module nv_nvdla_sdp_nrdma_slcg_ctrl #(
    parameter int OUTS_W    = 8,
    parameter int IDLE_HOLD = 16,
    parameter int HOLD_W    = 5
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rstn,
    input  logic              reg2dp_op_en,
    input  logic              reg2dp_nrdma_disable,
    input  logic              layer_done,
    input  logic              dma_rd_req_valid,
    input  logic              dma_rd_req_ready,
    input  logic              dma_rd_rsp_valid,
    input  logic              dma_rd_rsp_ready,
    output logic              nrdma_slcg_op_en,
    output logic              nrdma_disable,
    output logic              ctrl_busy,
    output logic [OUTS_W-1:0] outs_cnt,
    output logic              err_overflow,
    output logic              err_underflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DRAIN,
        S_HOLD
    } state_t;

    localparam logic [OUTS_W-1:0] CNT_MAX = '1;
    localparam logic [HOLD_W-1:0] HOLD_LD = HOLD_W'(IDLE_HOLD - 1);

    state_t            state;
    state_t            state_nxt;
    logic              op_en_d;
    logic              op_en_rise;
    logic              start;
    logic              inc;
    logic              dec;
    logic [OUTS_W-1:0] cnt_nxt;
    logic              ovf_set;
    logic              unf_set;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;

    assign op_en_rise = reg2dp_op_en & ~op_en_d;
    assign start      = op_en_rise & ~reg2dp_nrdma_disable;
    assign inc        = dma_rd_req_valid & dma_rd_req_ready;
    assign dec        = dma_rd_rsp_valid & dma_rd_rsp_ready;

    // Outstanding-read count: saturating, simultaneous inc/dec cancels
    always_comb begin
        cnt_nxt = outs_cnt;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (inc && !dec) begin
            if (outs_cnt == CNT_MAX) ovf_set = 1'b1;
            else                     cnt_nxt = outs_cnt + 1'b1;
        end else if (dec && !inc) begin
            if (outs_cnt == '0) unf_set = 1'b1;
            else                cnt_nxt = outs_cnt - 1'b1;
        end
    end

    // Next state; a restart in HOLD wins over hold expiry
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start) state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (layer_done)
                    state_nxt = (cnt_nxt != '0) ? S_DRAIN : S_HOLD;
            end
            S_DRAIN: begin
                if (cnt_nxt == '0) state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (start)               state_nxt = S_ACTIVE;
                else if (hold_cnt == '0) state_nxt = S_IDLE;
            end
        endcase
    end

    // Hold counter reloads on every HOLD entry, then counts down
    always_comb begin
        hold_nxt = hold_cnt;
        if (state_nxt == S_HOLD && state != S_HOLD)
            hold_nxt = HOLD_LD;
        else if (state == S_HOLD && hold_cnt != '0)
            hold_nxt = hold_cnt - 1'b1;
    end

    // State, counters and registered gate outputs
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state            <= S_IDLE;
            op_en_d          <= 1'b0;
            hold_cnt         <= '0;
            outs_cnt         <= '0;
            err_overflow     <= 1'b0;
            err_underflow    <= 1'b0;
            nrdma_slcg_op_en <= 1'b0;
            nrdma_disable    <= 1'b1;
            ctrl_busy        <= 1'b0;
        end else begin
            state            <= state_nxt;
            op_en_d          <= reg2dp_op_en;
            hold_cnt         <= hold_nxt;
            outs_cnt         <= cnt_nxt;
            err_overflow     <= err_overflow | ovf_set;
            err_underflow    <= err_underflow | unf_set;
            nrdma_slcg_op_en <= (state_nxt != S_IDLE);
            nrdma_disable    <= (state_nxt == S_IDLE);
            ctrl_busy        <= (state_nxt == S_ACTIVE) ||
                                (state_nxt == S_DRAIN);
        end
    end

endmodule

// File: doc/nv_nvdla_sdp_nrdma_slcg_ctrl.md
Name: nv_nvdla_sdp_nrdma_slcg_ctrl

Overview:
Upstream control stage for the SDP NRDMA clock gate. It produces `nrdma_slcg_op_en` and `nrdma_disable` from the layer start (`op_en`), the register-level NRDMA-disable field and the live DMA read traffic. The gated NRDMA clock stays requested from layer start until all outstanding reads have returned, plus a programmable idle hold. This prevents the clock from toggling off and on between back-to-back layers.

Parameters:
OUTS_W, 8, width of the outstanding-read counter (max outstanding = 2^OUTS_W-1)
IDLE_HOLD, 16, cycles the clock request is held after drain completes; must be >=1
HOLD_W, 5, width of the hold counter; must hold IDLE_HOLD-1

Ports:
nvdla_core_clk  input  1  core clock
nvdla_core_rstn  input  1  asynchronous active-low reset
reg2dp_op_en  input  1  layer operation enable level; a rising edge starts a layer
reg2dp_nrdma_disable  input  1  NRDMA unused for this layer; sampled at the op_en rising edge
layer_done  input  1  single-cycle pulse from the SDP core at end of layer
dma_rd_req_valid  input  1  NRDMA read request valid
dma_rd_req_ready  input  1  NRDMA read request accepted
dma_rd_rsp_valid  input  1  NRDMA read response valid (one response per request)
dma_rd_rsp_ready  input  1  NRDMA read response consumed
nrdma_slcg_op_en  output  1  clock request to the NRDMA gate
nrdma_disable  output  1  NRDMA disable to the NRDMA gate
ctrl_busy  output  1  state is ACTIVE or DRAIN
outs_cnt  output  OUTS_W  current outstanding-read count
err_overflow  output  1  sticky: increment attempted at max count
err_underflow  output  1  sticky: decrement attempted at zero

Behaviour:
- Clock and reset: `nvdla_core_clk` is the clock; `nvdla_core_rstn` is an asynchronous, active-low reset. All state and outputs are flops on `nvdla_core_clk`.
- Reset values:
  - state = IDLE
  - `nrdma_slcg_op_en` = 0, `nrdma_disable` = 1, `ctrl_busy` = 0
  - `outs_cnt` = 0, `err_overflow` = 0, `err_underflow` = 0
  - hold counter = 0, `op_en_d` = 0
- Start detect: `op_en_rise = reg2dp_op_en & ~op_en_d`, where `op_en_d` is `reg2dp_op_en` registered one cycle.
- FSM states: IDLE, ACTIVE, DRAIN, HOLD.
  - IDLE -> ACTIVE on `op_en_rise` with `reg2dp_nrdma_disable`=0.
  - IDLE: `op_en_rise` with `reg2dp_nrdma_disable`=1 keeps the FSM in IDLE; outputs are unchanged.
  - ACTIVE -> DRAIN on `layer_done` when the next-cycle count is nonzero.
  - ACTIVE -> HOLD on `layer_done` when the next-cycle count is 0.
  - DRAIN -> HOLD when the next-cycle count is 0. The hold counter loads IDLE_HOLD-1 on every entry to HOLD.
  - HOLD: the counter decrements each cycle. HOLD -> IDLE in the cycle the counter is 0.
  - HOLD -> ACTIVE on `op_en_rise` with `reg2dp_nrdma_disable`=0. This takes priority over expiry; the clock request never drops.
  - `op_en_rise` in ACTIVE or DRAIN is ignored.
  - `layer_done` outside ACTIVE is ignored.
- Output timing: `nrdma_slcg_op_en` = (next_state != IDLE) and `nrdma_disable` = ~`nrdma_slcg_op_en`, both registered.
  - The clock request rises 1 cycle after the cycle in which `op_en_rise` is true.
  - It falls 1 cycle after HOLD expires.
  - Minimum request-on time after drain is IDLE_HOLD cycles.
- `ctrl_busy`: registered (next_state is ACTIVE or DRAIN).
- Outstanding counter (counts in all states):
  - inc = `dma_rd_req_valid & dma_rd_req_ready`; dec = `dma_rd_rsp_valid & dma_rd_rsp_ready`.
  - inc and dec in the same cycle: count unchanged, no error, even at 0 or max.
  - inc alone at 2^OUTS_W-1: count saturates and `err_overflow` sets.
  - dec alone at 0: count stays 0 and `err_underflow` sets.
  - Both error bits clear only on reset.
  - The FSM uses the next-cycle count value.
- Reset mid-operation: asynchronous return to the reset values above. The outstanding count is discarded.

Test Plan:
- Basic layer: reset, `op_en` rise at cycle 10 with `reg2dp_nrdma_disable`=0, no traffic, `layer_done` at cycle 20 -> `nrdma_slcg_op_en`=1 from cycle 11; HOLD entered at cycle 21; request drops 1 cycle after HOLD expires, 16 cycles after entry.
- Drain: 5 accepted requests, `layer_done` with 3 responses outstanding, then 3 responses 1 per 4 cycles -> DRAIN, `ctrl_busy`=1 until the last response; HOLD for 16 cycles; `outs_cnt` returns to 0.
- Back-to-back: new `op_en` rise at HOLD cycle 8 -> returns to ACTIVE; `nrdma_slcg_op_en` never drops; hold counter reloads to 15 on the next HOLD entry.
- Disabled layer: `op_en` rise with `reg2dp_nrdma_disable`=1 -> `nrdma_disable` stays 1 and state stays IDLE; traffic still updates `outs_cnt`.
- Counter edges: simultaneous inc and dec at count 0 -> count 0, no error; dec alone at 0 -> `err_underflow`=1 and sticky; with OUTS_W=2, 4 incs -> count 3 and `err_overflow`=1.
- Reset: assert `nvdla_core_rstn` low in DRAIN with `outs_cnt`=7 -> immediately IDLE, `nrdma_disable`=1, `outs_cnt`=0, errors 0.
